fetch_sequencer: RTL and testbench

Multicycle instruction-fetch front end. Owns the PC, fetches each instruction word from instruction memory over a req/ack handshake, and holds it stable for the decode/control path. Drives op and funct to the controller. Consumes the controller's resolved pcsrc/jump decision at end of execute and computes the next PC. Sits between instruction memory and the controller/datapath.

---
 rtl/fetch_sequencer.sv | 156 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Multicycle instruction-fetch front end. Owns the PC, fetches one
//   instruction word at a time from instruction memory over a req/ack
//   handshake, holds the word stable while the controller executes it, and
//   computes the next PC from the controller's resolved pcsrc/jump decision.
//
// Ports
//   clk, reset         rising-edge clock, synchronous active-high reset
//   run                level; high permits fetching (sampled in IDLE and on
//                      the exec_done edge only)
//   imem_req/addr      fetch request and address (addr = pc)
//   imem_ack/rdata     memory response; rdata is valid when ack is high
//   instr, op, funct   latched instruction and its opcode/funct slices
//   instr_valid        instruction is being executed (ISSUE state)
//   exec_done          execute complete; pcsrc/jump valid this cycle
//   pcsrc, jump        branch-taken and jump decisions (jump has priority)
//   pc, pcplus4        current instruction address and pc + 4
//   retired            number of completed instructions, wraps at 2^32
// -----------------------------------------------------------------------------
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [5:0]  funct,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic        pcsrc,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] pcplus4,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] retired_q, retired_d;
  logic        req_q, req_d;
  logic        valid_q, valid_d;

  logic [31:0] pcplus4_s;
  logic [31:0] br_off_s;
  logic [31:0] next_pc_s;

  // Sequential PC increment and sign-extended, word-scaled branch offset.
  always_comb begin
    pcplus4_s = pc_q + 32'd4;
    br_off_s  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  end

  // Next-PC selection: jump outranks branch, branch outranks sequential.
  always_comb begin
    next_pc_s = pcplus4_s;
    if (jump) begin
      next_pc_s = {pcplus4_s[31:28], instr_q[25:0], 2'b00};
    end else if (pcsrc) begin
      next_pc_s = pcplus4_s + br_off_s;
    end else begin
      next_pc_s = pcplus4_s;
    end
  end

  // FSM next-state and datapath register updates.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        // run is deliberately not looked at here: a started fetch completes.
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_ISSUE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_ISSUE: begin
        if (exec_done) begin
          pc_d      = next_pc_s;
          retired_d = retired_q + 32'd1;
          if (run) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Handshake flags are registered from the next state so the outputs come
    // straight from flops.
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_ISSUE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= 32'h0000_0000;
      retired_q <= 32'h0000_0000;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      retired_q <= retired_d;
      req_q     <= req_d;
      valid_q   <= valid_d;
    end
  end

  // Output mapping; op/funct are plain slices of the latched word.
  always_comb begin
    imem_req    = req_q;
    imem_addr   = pc_q;
    instr       = instr_q;
    op          = instr_q[31:26];
    funct       = instr_q[5:0];
    instr_valid = valid_q;
    pc          = pc_q;
    pcplus4     = pcplus4_s;
    retired     = retired_q;
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, run_hi, imem_ack, exec_done, pcsrc, jump;
  logic [31:0] imem_rdata;

  logic        imem_req, instr_valid;
  logic [31:0] imem_addr, instr, pc, pcplus4, retired;
  logic [5:0]  op, funct;

  logic        hi_req, hi_valid;
  logic [31:0] hi_addr, hi_instr, hi_pc, hi_pcplus4, hi_retired;
  logic [5:0]  hi_op, hi_funct;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: architectural state only
  logic [31:0] m_pc, m_instr, m_retired;

  fetch_sequencer u_dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(instr), .op(op), .funct(funct), .instr_valid(instr_valid),
    .exec_done(exec_done), .pcsrc(pcsrc), .jump(jump),
    .pc(pc), .pcplus4(pcplus4), .retired(retired)
  );

  fetch_sequencer #(.RESET_PC(32'h8000_0010)) u_dut_hi (
    .clk(clk), .reset(reset), .run(run_hi),
    .imem_req(hi_req), .imem_addr(hi_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instr(hi_instr), .op(hi_op), .funct(hi_funct), .instr_valid(hi_valid),
    .exec_done(exec_done), .pcsrc(pcsrc), .jump(jump),
    .pc(hi_pc), .pcplus4(hi_pcplus4), .retired(hi_retired)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Next PC from the architectural rules, using plain arithmetic.
  function automatic logic [31:0] ref_next(input logic [31:0] cur, input logic [31:0] ins,
                                           input logic br, input logic jmp);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (jmp) return (seq & 32'hF000_0000) | (32'(ins[25:0]) * 32'd4);
    off = int'($signed(ins[15:0]));
    if (br) return seq + 32'(off * 4);
    return seq;
  endfunction

  // One complete instruction on the main DUT, starting with it in FETCH.
  task automatic fetch_issue(input logic [31:0] rdata, input int ack_dly, input int ex_dly,
                             input logic br, input logic jmp, input logic run_after);
    n_checks += 2;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL fetch_req: got %b expected 1", imem_req); end
    if (imem_addr !== m_pc) begin n_fail++; $display("FAIL fetch_addr: got %h expected %h", imem_addr, m_pc); end
    for (int i = 0; i < ack_dly; i++) begin
      imem_ack = 1'b0; imem_rdata = $urandom; exec_done = 1'($urandom); run = 1'($urandom);
      tick();
      n_checks += 4;
      if (imem_req !== 1'b1) begin n_fail++; $display("FAIL wait_req: got %b expected 1", imem_req); end
      if (imem_addr !== m_pc) begin n_fail++; $display("FAIL wait_addr: got %h expected %h", imem_addr, m_pc); end
      if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL wait_valid: got %b expected 0", instr_valid); end
      if (instr !== m_instr) begin n_fail++; $display("FAIL wait_instr: got %h expected %h", instr, m_instr); end
    end
    imem_ack = 1'b1; imem_rdata = rdata; exec_done = 1'($urandom); run = 1'($urandom);
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom; exec_done = 1'b0;
    m_instr = rdata;
    n_checks += 7;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL issue_valid: got %b expected 1", instr_valid); end
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL issue_req: got %b expected 0", imem_req); end
    if (instr !== rdata) begin n_fail++; $display("FAIL issue_instr: got %h expected %h", instr, rdata); end
    if (op !== rdata[31:26]) begin n_fail++; $display("FAIL issue_op: got %h expected %h", op, rdata[31:26]); end
    if (funct !== rdata[5:0]) begin n_fail++; $display("FAIL issue_funct: got %h expected %h", funct, rdata[5:0]); end
    if (pc !== m_pc) begin n_fail++; $display("FAIL issue_pc: got %h expected %h", pc, m_pc); end
    if (pcplus4 !== m_pc + 32'd4) begin n_fail++; $display("FAIL issue_pcplus4: got %h expected %h", pcplus4, m_pc + 32'd4); end
    for (int i = 0; i < ex_dly; i++) begin
      exec_done = 1'b0; pcsrc = 1'($urandom); jump = 1'($urandom); run = 1'($urandom);
      imem_ack = 1'($urandom);
      tick();
      n_checks += 3;
      if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL hold_valid: got %b expected 1", instr_valid); end
      if (instr !== m_instr) begin n_fail++; $display("FAIL hold_instr: got %h expected %h", instr, m_instr); end
      if (pc !== m_pc) begin n_fail++; $display("FAIL hold_pc: got %h expected %h", pc, m_pc); end
    end
    exec_done = 1'b1; pcsrc = br; jump = jmp; run = run_after; imem_ack = 1'b0;
    tick();
    exec_done = 1'b0; pcsrc = 1'b0; jump = 1'b0;
    m_pc = ref_next(m_pc, m_instr, br, jmp);
    m_retired = m_retired + 32'd1;
    n_checks += 4;
    if (pc !== m_pc) begin n_fail++; $display("FAIL done_pc: got %h expected %h", pc, m_pc); end
    if (retired !== m_retired) begin n_fail++; $display("FAIL done_retired: got %h expected %h", retired, m_retired); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL done_valid: got %b expected 0", instr_valid); end
    if (imem_req !== run_after) begin n_fail++; $display("FAIL done_req: got %b expected %b", imem_req, run_after); end
  endtask

  task automatic check_reset_state(input string tag);
    n_checks += 6;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL %s_req: got %b expected 0", tag, imem_req); end
    if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL %s_valid: got %b expected 0", tag, instr_valid); end
    if (pc !== 32'h0) begin n_fail++; $display("FAIL %s_pc: got %h expected 0", tag, pc); end
    if (instr !== 32'h0) begin n_fail++; $display("FAIL %s_instr: got %h expected 0", tag, instr); end
    if (retired !== 32'h0) begin n_fail++; $display("FAIL %s_retired: got %h expected 0", tag, retired); end
    if (pcplus4 !== 32'd4) begin n_fail++; $display("FAIL %s_pcplus4: got %h expected 4", tag, pcplus4); end
    m_pc = 32'h0; m_instr = 32'h0; m_retired = 32'h0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0; run_hi = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
    pcsrc = 1'b0; jump = 1'b0; imem_rdata = 32'h0;
    tick(); tick();
    reset = 1'b0;
    check_reset_state("reset");
    n_checks += 2;
    if (hi_pc !== 32'h8000_0010) begin n_fail++; $display("FAIL reset_hi_pc: got %h expected 80000010", hi_pc); end
    if (hi_req !== 1'b0) begin n_fail++; $display("FAIL reset_hi_req: got %b expected 0", hi_req); end
    // ack and exec_done while idle must be ignored
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; exec_done = 1'b1; jump = 1'b1; pcsrc = 1'b1;
    tick(); tick();
    imem_ack = 1'b0; exec_done = 1'b0; jump = 1'b0; pcsrc = 1'b0;
    check_reset_state("idle_ignore");
  endtask

  task automatic test_jump_wins();
    logic [31:0] exp_pc;
    exp_pc = ref_next(32'h8000_0010, 32'h0800_0100, 1'b1, 1'b1);
    run_hi = 1'b1;
    tick();
    run_hi = 1'b0;
    n_checks += 2;
    if (hi_req !== 1'b1) begin n_fail++; $display("FAIL jw_req: got %b expected 1", hi_req); end
    if (hi_addr !== 32'h8000_0010) begin n_fail++; $display("FAIL jw_addr: got %h expected 80000010", hi_addr); end
    imem_ack = 1'b1; imem_rdata = 32'h0800_0100;
    tick();
    imem_ack = 1'b0;
    n_checks += 4;
    if (hi_valid !== 1'b1) begin n_fail++; $display("FAIL jw_valid: got %b expected 1", hi_valid); end
    if (hi_instr !== 32'h0800_0100) begin n_fail++; $display("FAIL jw_instr: got %h expected 08000100", hi_instr); end
    if (hi_op !== 6'h02) begin n_fail++; $display("FAIL jw_op: got %h expected 02", hi_op); end
    if (hi_funct !== 6'h00) begin n_fail++; $display("FAIL jw_funct: got %h expected 00", hi_funct); end
    exec_done = 1'b1; jump = 1'b1; pcsrc = 1'b1;
    tick();
    exec_done = 1'b0; jump = 1'b0; pcsrc = 1'b0;
    n_checks += 6;
    if (hi_pc !== 32'h8000_0400) begin n_fail++; $display("FAIL jw_pc_const: got %h expected 80000400", hi_pc); end
    if (hi_pc !== exp_pc) begin n_fail++; $display("FAIL jw_pc_model: got %h expected %h", hi_pc, exp_pc); end
    if (hi_pcplus4 !== 32'h8000_0404) begin n_fail++; $display("FAIL jw_pcplus4: got %h expected 80000404", hi_pcplus4); end
    if (hi_retired !== 32'd1) begin n_fail++; $display("FAIL jw_retired: got %h expected 1", hi_retired); end
    if (hi_req !== 1'b0) begin n_fail++; $display("FAIL jw_idle_req: got %b expected 0", hi_req); end
    if (instr !== 32'h0) begin n_fail++; $display("FAIL jw_main_untouched: got %h expected 0", instr); end
  endtask

  task automatic test_basic();
    run = 1'b1;
    tick();
    fetch_issue(32'h2008_0005, 0, 0, 1'b0, 1'b0, 1'b1);
    n_checks += 2;
    if (pc !== 32'd4) begin n_fail++; $display("FAIL basic_pc: got %h expected 4", pc); end
    if (retired !== 32'd1) begin n_fail++; $display("FAIL basic_retired: got %h expected 1", retired); end
  endtask

  task automatic test_ack_delay();
    fetch_issue($urandom, 3, 2, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_branch();
    // pc = 8 here; jump to 0x40
    fetch_issue(32'h0800_0010, 0, 1, 1'b0, 1'b1, 1'b1);
    n_checks += 1;
    if (pc !== 32'h40) begin n_fail++; $display("FAIL br_jump_pc: got %h expected 40", pc); end
    fetch_issue(32'h1000_FFFF, 1, 0, 1'b1, 1'b0, 1'b1);
    n_checks += 1;
    if (pc !== 32'h40) begin n_fail++; $display("FAIL br_back_pc: got %h expected 40", pc); end
    fetch_issue(32'h1000_0003, 0, 0, 1'b1, 1'b0, 1'b1);
    n_checks += 1;
    if (pc !== 32'h50) begin n_fail++; $display("FAIL br_fwd_pc: got %h expected 50", pc); end
  endtask

  task automatic test_wrap();
    // 0x54 - 0x58 wraps below zero
    fetch_issue(32'h1000_FFEA, 0, 0, 1'b1, 1'b0, 1'b1);
    n_checks += 1;
    if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_br_pc: got %h expected fffffffc", pc); end
    fetch_issue($urandom, 1, 1, 1'b0, 1'b0, 1'b1);
    n_checks += 1;
    if (pc !== 32'h0) begin n_fail++; $display("FAIL wrap_seq_pc: got %h expected 0", pc); end
  endtask

  task automatic resume_from_idle();
    imem_ack = 1'b0; exec_done = 1'b0; run = 1'b1;
    tick();
    n_checks += 2;
    if (imem_req !== 1'b1) begin n_fail++; $display("FAIL resume_req: got %b expected 1", imem_req); end
    if (imem_addr !== m_pc) begin n_fail++; $display("FAIL resume_addr: got %h expected %h", imem_addr, m_pc); end
  endtask

  task automatic test_run_drop();
    fetch_issue($urandom, 0, 1, 1'b0, 1'b0, 1'b0);
    imem_ack = 1'b1; exec_done = 1'b1; run = 1'b0; imem_rdata = $urandom;
    tick(); tick();
    n_checks += 4;
    if (imem_req !== 1'b0) begin n_fail++; $display("FAIL drop_req: got %b expected 0", imem_req); end
    if (pc !== m_pc) begin n_fail++; $display("FAIL drop_pc: got %h expected %h", pc, m_pc); end
    if (instr !== m_instr) begin n_fail++; $display("FAIL drop_instr: got %h expected %h", instr, m_instr); end
    if (retired !== m_retired) begin n_fail++; $display("FAIL drop_retired: got %h expected %h", retired, m_retired); end
    resume_from_idle();
    fetch_issue($urandom, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    logic fetching;
    logic ra;
    fetching = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (!fetching) resume_from_idle();
      ra = ($urandom_range(0, 3) != 0);
      fetch_issue($urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom), 1'($urandom), ra);
      fetching = ra;
    end
    if (!fetching) resume_from_idle();
  endtask

  task automatic test_reset_mid_fetch();
    // DUT is in FETCH waiting on ack
    imem_ack = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
    check_reset_state("rst_fetch");
    tick();
    imem_ack = 1'b0;
    check_reset_state("rst_fetch_ack");
  endtask

  task automatic test_reset_mid_issue();
    run = 1'b1;
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ack = 1'b0;
    n_checks += 1;
    if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL rst_issue_pre: got %b expected 1", instr_valid); end
    reset = 1'b1; exec_done = 1'b1; jump = 1'b1;
    tick();
    reset = 1'b0; exec_done = 1'b0; jump = 1'b0; run = 1'b0;
    check_reset_state("rst_issue");
  endtask

  initial begin
    test_reset();
    test_jump_wins();
    test_basic();
    test_ack_delay();
    test_branch();
    test_wrap();
    test_run_drop();
    test_random();
    test_reset_mid_fetch();
    test_reset_mid_issue();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
